tcam_rule_writer: RTL and testbench

// - Programming side of the ternary match array: accepts host rule commands and writes the
//   (value, care) pairs that per-bit match cells consume as rule 1 / 0 / don't-care.
// - Sequences every update as invalidate -> write -> arm, so a half-written entry never matches.
// - Sits between the host command port and the TCAM entry storage plus the entry-valid vector.

---
 rtl/tcam_pkg.sv | 17 +
 rtl/tcam_rule_writer.sv | 184 ++++++++++++++++++
 tb/tb_tcam_rule_writer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// Shared op encodings and FSM state type for the TCAM rule writer.
package tcam_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_INVAL = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    KILL,
    PROG,
    ARM,
    SWEEP,
    ERR
  } state_e;

endpackage

// File: rtl/tcam_rule_writer.sv
// Host-side TCAM programmer: sequences every update as invalidate -> write -> arm
// so a half-written entry can never match.
//
// state | meaning
// IDLE  | ready for a host command
// KILL  | target entry disabled (INVALIDATE completes here)
// PROG  | storage write of value/care
// ARM   | target entry re-enabled, done
// SWEEP | CLEAR_ALL walk over every entry
// ERR   | rejected command, done+err
module tcam_rule_writer
  import tcam_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_index,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic [WIDTH-1:0] cmd_care,
  output logic             tcam_we,
  output logic [IDX_W-1:0] tcam_index,
  output logic [WIDTH-1:0] tcam_value,
  output logic [WIDTH-1:0] tcam_care,
  output logic [DEPTH-1:0] entry_valid,
  output logic             search_hold,
  output logic             done,
  output logic             err
);

  // One extra bit so DEPTH == 2**IDX_W stays representable in the range check.
  localparam logic [IDX_W:0]   DEPTH_X = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [DEPTH-1:0] ONE     = DEPTH'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] care_q, care_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             tcam_we_q, tcam_we_d;
  logic [IDX_W-1:0] tcam_index_q, tcam_index_d;
  logic [WIDTH-1:0] tcam_value_q, tcam_value_d;
  logic [WIDTH-1:0] tcam_care_q, tcam_care_d;
  logic [DEPTH-1:0] ev_q, ev_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cmd_in_range;
  logic [IDX_W-1:0] cnt_nxt;

  assign cmd_in_range = {1'b0, cmd_index} < DEPTH_X;
  assign cnt_nxt      = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    val_d        = val_q;
    care_d       = care_q;
    cnt_d        = cnt_q;
    tcam_we_d    = 1'b0;
    tcam_index_d = tcam_index_q;
    tcam_value_d = tcam_value_q;
    tcam_care_d  = tcam_care_q;
    ev_d         = ev_q;
    hold_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          idx_d  = cmd_index;
          val_d  = cmd_value;
          care_d = cmd_care;
          if (cmd_op == OP_CLEAR) begin
            state_d      = SWEEP;
            cnt_d        = '0;
            tcam_we_d    = 1'b1;
            tcam_index_d = '0;
            tcam_value_d = '0;
            tcam_care_d  = '0;
            ev_d         = ev_q & ~ONE;
            hold_d       = 1'b1;
          end else if (cmd_in_range && (cmd_op == OP_WRITE || cmd_op == OP_INVAL)) begin
            state_d = KILL;
            ev_d    = ev_q & ~(ONE << cmd_index);
            hold_d  = 1'b1;
            done_d  = (cmd_op == OP_INVAL);
          end else begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      KILL: begin
        if (op_q == OP_WRITE) begin
          state_d      = PROG;
          tcam_we_d    = 1'b1;
          tcam_index_d = idx_q;
          tcam_value_d = val_q & care_q;
          tcam_care_d  = care_q;
          hold_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PROG: begin
        state_d = ARM;
        ev_d    = ev_q | (ONE << idx_q);
        done_d  = 1'b1;
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d        = cnt_nxt;
          tcam_we_d    = 1'b1;
          tcam_index_d = cnt_nxt;
          tcam_value_d = '0;
          tcam_care_d  = '0;
          ev_d         = ev_q & ~(ONE << cnt_nxt);
          hold_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      care_q       <= '0;
      cnt_q        <= '0;
      tcam_we_q    <= 1'b0;
      tcam_index_q <= '0;
      tcam_value_q <= '0;
      tcam_care_q  <= '0;
      ev_q         <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      care_q       <= care_d;
      cnt_q        <= cnt_d;
      tcam_we_q    <= tcam_we_d;
      tcam_index_q <= tcam_index_d;
      tcam_value_q <= tcam_value_d;
      tcam_care_q  <= tcam_care_d;
      ev_q         <= ev_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign tcam_we     = tcam_we_q;
  assign tcam_index  = tcam_index_q;
  assign tcam_value  = tcam_value_q;
  assign tcam_care   = tcam_care_q;
  assign entry_valid = ev_q;
  assign search_hold = hold_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Scoreboard bench for tcam_rule_writer: directed and random commands, reference
// model in plain arrays/queues, monitor pops expectations on tcam_we and done.
module tb_tcam_rule_writer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [IDX_W-1:0] cmd_index = '0;
  logic [WIDTH-1:0] cmd_value = '0;
  logic [WIDTH-1:0] cmd_care = '0;
  logic             tcam_we;
  logic [IDX_W-1:0] tcam_index;
  logic [WIDTH-1:0] tcam_value;
  logic [WIDTH-1:0] tcam_care;
  logic [DEPTH-1:0] entry_valid;
  logic             search_hold;
  logic             done;
  logic             err;

  tcam_rule_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_value(cmd_value), .cmd_care(cmd_care),
    .tcam_we(tcam_we), .tcam_index(tcam_index), .tcam_value(tcam_value),
    .tcam_care(tcam_care), .entry_valid(entry_valid), .search_hold(search_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] care;
    int               acc;
    int               off;
  } wr_t;

  typedef struct {
    bit               err;
    int               acc;
    int               lat;
    int               hold;
    logic [DEPTH-1:0] ev;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  bit  model_ev[DEPTH];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int hold_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [DEPTH-1:0] model_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = model_ev[i];
    return v;
  endfunction

  // Monitor: pops an expected write on every tcam_we and an expected completion on every done.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (rst_n) begin
      if (search_hold) hold_cnt++;
      if (tcam_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_tcam_we", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("wr_index", 64'(tcam_index), 64'(w.idx));
          chk("wr_value", 64'(tcam_value), 64'(w.val));
          chk("wr_care", 64'(tcam_care), 64'(w.care));
          chk("wr_timing", 64'(cyc - w.acc), 64'(w.off));
          chk("wr_entry_disabled", 64'(entry_valid[w.idx[4:0]]), 0);
        end
      end
      if (err && !done) chk("err_without_done", 1, 0);
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = dq.pop_front();
          chk("done_err", 64'(err), 64'(d.err));
          chk("done_latency", 64'(cyc - d.acc + 1), 64'(d.lat));
          chk("done_hold_cycles", 64'(hold_cnt), 64'(d.hold));
          chk("done_entry_valid", 64'(entry_valid), 64'(d.ev));
        end
        hold_cnt = 0;
      end
    end
  end

  // Reference behaviour: expected writes, completion and entry-valid state from the op rules.
  task automatic expect_cmd(input logic [1:0] op, input int idx, input logic [WIDTH-1:0] val,
                            input logic [WIDTH-1:0] care, input int acc);
    dn_t d;
    bit  in_rng;
    in_rng = idx < DEPTH;
    d.err  = 0;
    d.acc  = acc;
    if (op == 2'b10) begin
      for (int i = 0; i < DEPTH; i++) begin
        wq.push_back('{idx: IDX_W'(i), val: '0, care: '0, acc: acc, off: i});
        model_ev[i] = 0;
      end
      d.lat = DEPTH + 1;
      d.hold = DEPTH;
    end else if (op == 2'b00 && in_rng) begin
      wq.push_back('{idx: IDX_W'(idx), val: val & care, care: care, acc: acc, off: 1});
      model_ev[idx] = 1;
      d.lat = 3;
      d.hold = 2;
    end else if (op == 2'b01 && in_rng) begin
      model_ev[idx] = 0;
      d.lat = 1;
      d.hold = 1;
    end else begin
      d.err = 1;
      d.lat = 1;
      d.hold = 0;
    end
    d.ev = model_vec();
    dq.push_back(d);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at a negedge once the writer is idle again.
  task automatic issue(input logic [1:0] op, input int idx, input logic [WIDTH-1:0] val,
                       input logic [WIDTH-1:0] care);
    int n;
    wait_ready();
    expect_cmd(op, idx, val, care, cyc + 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = IDX_W'(idx);
    cmd_value = val;
    cmd_care  = care;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_index = IDX_W'($urandom);
      cmd_value = WIDTH'($urandom);
      cmd_care  = WIDTH'($urandom);
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [1:0] op;
    for (int i = 0; i < DEPTH; i++) model_ev[i] = 0;

    #1;
    chk("rst_ready", 64'(cmd_ready), 1);
    chk("rst_we", 64'(tcam_we), 0);
    chk("rst_index_value_care", 64'({tcam_index, tcam_value, tcam_care}), 0);
    chk("rst_entry_valid", 64'(entry_valid), 0);
    chk("rst_hold_done_err", 64'({search_hold, done, err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 3, 16'hA5A5, 16'hFF00);
    issue(2'b00, 3, 16'h1234, 16'hFFFF);
    issue(2'b01, 3, 16'h0, 16'h0);
    issue(2'b00, 40, 16'hBEEF, 16'hFFFF);
    issue(2'b11, 5, 16'h1111, 16'hFFFF);
    issue(2'b00, 0, 16'hFFFF, 16'h0F0F);
    issue(2'b00, 31, 16'h8001, 16'hC003);
    issue(2'b10, 0, 16'h0, 16'h0);

    for (int k = 0; k < 200; k++) begin
      op  = 2'($urandom_range(0, 9) == 0 ? 2 : $urandom_range(0, 3));
      if (op == 2'b10 && $urandom_range(0, 1) == 1) op = 2'b00;
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH, 2**IDX_W - 1))
                                        : int'($urandom_range(0, DEPTH - 1));
      issue(op, idx, WIDTH'($urandom), WIDTH'($urandom));
    end

    // Reset during PROG of entry 7 after arming it.
    issue(2'b00, 7, 16'h7777, 16'hFFFF);
    wait_ready();
    wq.push_back('{idx: IDX_W'(7), val: 16'h00F0, care: 16'h0FF0, acc: cyc + 1, off: 1});
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_index = IDX_W'(7);
    cmd_value = 16'hF0F0;
    cmd_care  = 16'h0FF0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_seen", 64'(wq.size()), 0);
    chk("abort_ready", 64'(cmd_ready), 1);
    chk("abort_we", 64'(tcam_we), 0);
    chk("abort_index_value_care", 64'({tcam_index, tcam_value, tcam_care}), 0);
    chk("abort_entry_valid", 64'(entry_valid), 0);
    chk("abort_hold_done_err", 64'({search_hold, done, err}), 0);
    wq.delete();
    dq.delete();
    hold_cnt = 0;
    for (int i = 0; i < DEPTH; i++) model_ev[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 9, 16'h5A5A, 16'hF0F0);

    for (int n = 0; n < 200 && (wq.size() != 0 || dq.size() != 0); n++) @(negedge clk);
    chk("drain_writes", 64'(wq.size()), 0);
    chk("drain_dones", 64'(dq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
